reg_bank_8x32: RTL

8-entry x 32-bit architectural register bank with a busy-bit scoreboard. It sits directly upstream of the 32-bit 8:1 bus selector (mux_32bus_8x3). Its eight raw register outputs q0..q7 drive the selector's in0..in7 for operand selection. It also provides two internal read ports with write-through bypass and per-register busy tracking for hazard detection.

---
 rtl/nova_pkg.sv | 9 +
 rtl/reg32_en.sv | 23 ++
 rtl/reg_bank_8x32.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nova_pkg.sv
// Shared sizing constants and types for the architectural register bank.
package nova_pkg;
  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;
endpackage

// File: rtl/reg32_en.sv
// 32-bit storage register with synchronous active-high reset, load enable
// and a per-instance reset value.
module reg32_en
  import nova_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  word_t rst_val,
  input  word_t d,
  output word_t q
);

  // Storage: reset has priority over a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_8x32.sv
// 8 x 32-bit register bank with two bypassed read ports and a busy-bit
// scoreboard; q0..q7 expose the raw stored state to the downstream selector.
module reg_bank_8x32
  import nova_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ZERO_REG = 1,
  parameter int          BYPASS   = 1,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  input  logic              busy_set,
  input  logic [2:0]        busy_addr,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [DATA_W-1:0] q4,
  output logic [DATA_W-1:0] q5,
  output logic [DATA_W-1:0] q6,
  output logic [DATA_W-1:0] q7,
  output logic [7:0]        busy_vec
);

  localparam bit ZERO_EN_P   = (ZERO_REG != 0);
  localparam bit BYPASS_EN_P = (BYPASS != 0);

  word_t          regs_r [NUM_REGS];
  logic [7:0]     busy_vec_r;
  logic [7:0]     busy_nxt_s;
  logic           wr_live_s;
  logic           hit_a_s;
  logic           hit_b_s;

  // A write to a hardwired-zero register 0 is discarded everywhere.
  assign wr_live_s = wr_en && !(ZERO_EN_P && (wr_addr == 3'd0));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    localparam bit IS_ZERO_P = ZERO_EN_P && (i == 0);
    logic en_s;
    assign en_s = wr_live_s && (wr_addr == reg_addr_t'(i));
    reg32_en u_reg (
      .clk     (clk),
      .rst     (rst),
      .en      (en_s),
      .rst_val (IS_ZERO_P ? 32'h0000_0000 : RST_VAL),
      .d       (wr_data),
      .q       (regs_r[i])
    );
  end

  // Scoreboard next state: a new producer (set) outranks retiring the old one.
  always_comb begin
    busy_nxt_s = busy_vec_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (busy_set && (busy_addr == reg_addr_t'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (wr_en && (wr_addr == reg_addr_t'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_vec_r[i];
      end
    end
    if (ZERO_EN_P) begin
      busy_nxt_s[0] = 1'b0;
    end else begin
      busy_nxt_s[0] = busy_nxt_s[0];
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec_r <= 8'h00;
    end else begin
      busy_vec_r <= busy_nxt_s;
    end
  end

  assign hit_a_s = BYPASS_EN_P && wr_live_s && (wr_addr == rd_addr_a);
  assign hit_b_s = BYPASS_EN_P && wr_live_s && (wr_addr == rd_addr_b);

  // Read ports: forward in-flight write data and hide the busy it retires.
  always_comb begin
    if (hit_a_s) begin
      rd_data_a = wr_data;
      rd_busy_a = 1'b0;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
      rd_busy_a = busy_vec_r[rd_addr_a];
    end
    if (hit_b_s) begin
      rd_data_b = wr_data;
      rd_busy_b = 1'b0;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
      rd_busy_b = busy_vec_r[rd_addr_b];
    end
  end

  assign q0       = regs_r[0];
  assign q1       = regs_r[1];
  assign q2       = regs_r[2];
  assign q3       = regs_r[3];
  assign q4       = regs_r[4];
  assign q5       = regs_r[5];
  assign q6       = regs_r[6];
  assign q7       = regs_r[7];
  assign busy_vec = busy_vec_r;

endmodule
